ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side companion to the lab RAM/register datapath. On a start command it walks a contiguous, wrap-around window of the 64×8 data RAM through the RAM's asynchronous read port. It emits each byte on a valid/ready output stream, flags the final byte, and pulses done when the transfer completes. It sits beside the write path and owns the RAM read address whenever it is busy.

## Interface
Parameters:
- ADDR_W, 6, RAM address width (64 entries)
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-low
- start  in  1  begin transfer; sampled only in IDLE
- base_addr  in  ADDR_W  first RAM address; captured with start
- len  in  ADDR_W  byte count; 0 encodes 64; captured with start
- busy  out  1  high from the cycle after start until done
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DATA_W  RAM asynchronous read data, valid in the same cycle as rd_addr
- out_valid  out  1  out_data holds a byte
- out_ready  in  1  sink accepts the byte
- out_data  out  DATA_W  stream byte
- out_last  out  1  qualifies the final byte of the transfer
- done  out  1  one-cycle pulse after the final handshake

## Operation
- States are IDLE, FETCH, SEND and DONE; a CSUM state is added under the macro.
- IDLE
  - On start=1, capture ptr←base_addr and remaining←(len==0 ? 64 : len).
  - Go to FETCH.
- FETCH
  - rd_addr=ptr.
  - At the clock edge: out_data←rd_data, out_valid←1, out_last←(remaining==1), ptr←ptr+1 mod 64, remaining−1.
  - Go to SEND.
- SEND
  - rd_addr=ptr, which is already the next byte.
  - A handshake is out_valid & out_ready.
  - On a handshake with bytes left, load the next byte exactly as in FETCH and stay in SEND. Throughput is one byte per cycle.
  - On a handshake of the last byte: out_valid←0 and go to DONE.
  - Without a handshake, out_data and out_last hold stable.
- DONE
  - done=1 for one cycle.
  - Go to IDLE.
- A start asserted while busy is ignored.
- ptr uses ADDR_W-bit arithmetic and wraps 63→0 naturally.
- remaining is ADDR_W+1 bits wide.
- Each byte is taken from the live RAM at its load edge. A write to an address that has already been loaded has no effect on the stream.
- rd_addr is driven with ptr in IDLE as well; its value there is don't-care.

## Timing
- Reset values:
  - busy=0, out_valid=0, out_last=0, done=0, out_data=0, rd_addr=0.
  - State is IDLE and all counters are 0.
- Reset asserted mid-transfer aborts immediately: out_valid drops at that edge, no done pulse is produced, and any queued bytes are lost.
- Latency:
  - start sampled at edge 0 → state FETCH and busy=1 after edge 0.
  - First byte valid after edge 1.
- With out_ready held at 1, a transfer of N bytes occupies edges 1..N. done is high in the cycle after edge N+1.
- out_valid never deasserts without a handshake.
- out_last is only ever high while out_valid=1.

## Configuration
- READER_CSUM_EN, when defined:
  - An 8-bit sum accumulates every accepted byte (modulo 256) and clears on start.
  - After the last data byte handshakes, CSUM presents one extra byte equal to (−sum) mod 256, with out_last=1.
  - out_last is not asserted on the final data byte.
  - done follows the checksum handshake.
  - Result: the bytes of a transfer plus its checksum byte sum to 0.
- When undefined: the CSUM state, the accumulator and the extra byte are absent, and the stream is exactly len bytes.

## Structure
- Shared package ram_reader_pkg holds:
  - the ADDR_W and DATA_W defaults;
  - the state enum (IDLE, FETCH, SEND, DONE, CSUM);
  - the constant encoding len 0 as 64.
- One sub-module, ram_reader_csum (accumulator plus negation), is instantiated only under READER_CSUM_EN.
- The FSM, counters and output register stay in the top module.

## Test plan
- Basic read:
  - Stimulus: mem[5..7]=A1,B2,C3; start with base=5, len=3; out_ready=1.
  - Response: out_data A1,B2,C3 after edges 1,2,3; out_last only on C3; done one cycle after the C3 handshake.
- Wrap-around:
  - Stimulus: base=0x3E, len=4.
  - Response: rd_addr sequence 3E,3F,00,01; bytes match mem at those addresses in that order.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while byte 2 is presented.
  - Response: out_data and out_last stable and out_valid held high; no byte is skipped or duplicated.
- Full length:
  - Stimulus: len=0, base=0.
  - Response: 64 bytes in order mem[0..63]; busy high for 66 cycles; start pulses issued while busy are ignored.
- Reset mid-transfer:
  - Stimulus: rst=0 during byte 10.
  - Response: outputs at reset values after the edge and no done pulse; a subsequent start with base=0x20, len=2 runs normally.
- Checksum (with READER_CSUM_EN):
  - Stimulus: bytes 01,02,03.
  - Response: a fourth byte FA with out_last=1; done after its handshake.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared widths, reader FSM states and the len-0 encoding.
package ram_reader_pkg;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE, CSUM} state_e;

    // len of 0 stands for the full RAM depth.
    function automatic int unsigned len0_count(input int unsigned aw);
        return 32'd1 << aw;
    endfunction
endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: valid/ready byte stream carrying out_data and out_last.
interface ram_stream_reader_if #(parameter int DATA_W = 8) ();
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master(output valid, output data, output last, input ready);
    modport slave(input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_reader_csum.sv
// ram_reader_csum: running byte sum and its two's-complement negation.
module ram_reader_csum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] byte_i,
    output logic [DATA_W-1:0] neg_o
);
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] tot;

    always_ff @(posedge clk) begin
        if (!rst) sum_q <= '0;
        else if (clr_i) sum_q <= '0;
        else if (add_i) sum_q <= sum_q + byte_i;
    end

    // Include the byte being accepted this cycle so the result is ready at the last handshake.
    assign tot   = sum_q + (add_i ? byte_i : '0);
    assign neg_o = '0 - tot;
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a wrap-around RAM window out on a valid/ready port.
// Optional checksum trailer byte enabled by READER_CSUM_EN.
module ram_stream_reader
    import ram_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     len,
    output logic                  busy,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    ram_stream_reader_if.master   out,
    output logic                  done
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic              hs, load, last_data;

    assign hs = valid_q & out.ready;
`ifdef READER_CSUM_EN
    logic [DATA_W-1:0] csum;
    assign last_data = 1'b0;
    ram_reader_csum #(.DATA_W(DATA_W)) u_csum (
        .clk(clk),
        .rst(rst),
        .clr_i((state_q == IDLE) & start),
        .add_i((state_q == SEND) & hs),
        .byte_i(data_q),
        .neg_o(csum)
    );
`else
    assign last_data = rem_q == (ADDR_W+1)'(1);
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                ptr_d   = base_addr;
                rem_d   = (len == '0) ? (ADDR_W+1)'(len0_count(ADDR_W)) : {1'b0, len};
                state_d = FETCH;
            end
            FETCH: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: if (hs) begin
                if (rem_q != '0) load = 1'b1;
                else begin
`ifdef READER_CSUM_EN
                    data_d  = csum;
                    last_d  = 1'b1;
                    state_d = CSUM;
`else
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = DONE;
`endif
                end
            end
`ifdef READER_CSUM_EN
            CSUM: if (hs) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            data_d  = rd_data;
            valid_d = 1'b1;
            last_d  = last_data;
            ptr_d   = ptr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out.valid = valid_q;
    assign out.data  = data_q;
    assign out.last  = last_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign rd_addr   = ptr_q;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized transfers checked against a queue-based model of the stream.
module tb_ram_stream_reader;
`ifdef READER_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] base_addr = '0;
    logic [5:0] len = '0;
    logic       busy, done;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] mem [64];
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    ram_stream_reader_if #(.DATA_W(8)) s ();

    ram_stream_reader #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .len(len),
        .busy(busy),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .out(s),
        .done(done)
    );

    assign rd_data = mem[rd_addr];
    always #5 clk = ~clk;
    always @(negedge clk) if (busy === 1'b1) busy_cnt++;

    task automatic run_xfer(input int b, input int l, input int stall_pct, input int hold_idx,
                            input int abort_at, input bit spam);
        byte unsigned q[$];
        int n, idx, cyc, sum, held;
        bit aborted;
        n = (l == 0) ? 64 : l;
        sum = 0;
        held = 0;
        aborted = 0;
        for (int i = 0; i < n; i++) begin
            q.push_back(mem[(b + i) % 64]);
            sum += mem[(b + i) % 64];
        end
        if (CS == 1) q.push_back(8'((256 - sum % 256) % 256));
        @(negedge clk);
        start = 1'b1; base_addr = 6'(b); len = 6'(l); s.ready = 1'b0; busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < q.size() && cyc < 2000) begin
            if (idx == abort_at && s.valid === 1'b1) begin
                aborted = 1;
                break;
            end
            if (idx < n) begin
                checks++;
                if (rd_addr !== 6'((b + idx + (s.valid === 1'b1 ? 1 : 0)) % 64)) begin
                    errors++;
                    $display("FAIL rd_addr idx=%0d got %h want %h", idx, rd_addr,
                             6'((b + idx + (s.valid === 1'b1 ? 1 : 0)) % 64));
                end
            end
            if (s.valid === 1'b1) begin
                checks++;
                if (s.data !== q[idx]) begin
                    errors++;
                    $display("FAIL out_data idx=%0d got %h want %h", idx, s.data, q[idx]);
                end
                checks++;
                if (s.last !== (idx == q.size() - 1)) begin
                    errors++;
                    $display("FAIL out_last idx=%0d got %b want %b", idx, s.last, idx == q.size() - 1);
                end
            end else begin
                checks++;
                if (s.last !== 1'b0) begin
                    errors++;
                    $display("FAIL last_without_valid idx=%0d got %b want 0", idx, s.last);
                end
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_done_mid idx=%0d got busy=%b done=%b want busy=1 done=0", idx, busy, done);
            end
            if (spam) begin
                start = 1'($urandom);
                base_addr = 6'($urandom);
                len = 6'($urandom);
            end
            s.ready = ($urandom_range(99) >= 32'(stall_pct));
            if (idx == hold_idx && held < 3) begin
                s.ready = 1'b0;
                held++;
            end
            if (s.valid === 1'b1 && s.ready) idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, s.valid, s.last, done, s.data, rd_addr} !== 18'd0) begin
                errors++;
                $display("FAIL abort_reset got busy=%b valid=%b last=%b done=%b data=%h addr=%h want all 0",
                         busy, s.valid, s.last, done, s.data, rd_addr);
            end
            rst = 1'b1;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_no_done got busy=%b done=%b want 0 0", busy, done);
                end
            end
            return;
        end
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL timeout got %0d bytes want %0d", idx, q.size());
        end
        checks++;
        if (done !== 1'b1 || s.valid !== 1'b0 || s.last !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b valid=%b last=%b want 1 0 0", done, s.valid, s.last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_end got done=%b busy=%b want 0 0", done, busy);
        end
        if (stall_pct == 0 && hold_idx < 0) begin
            checks++;
            if (busy_cnt != n + 2 + CS || cyc != n + CS + 1) begin
                errors++;
                $display("FAIL timing got busy_cycles=%0d loop=%0d want %0d %0d", busy_cnt, cyc, n + 2 + CS, n + CS + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s.ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, s.valid, s.last, done, s.data, rd_addr} !== 18'd0) begin
            errors++;
            $display("FAIL reset got busy=%b valid=%b last=%b done=%b data=%h addr=%h want all 0",
                     busy, s.valid, s.last, done, s.data, rd_addr);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        mem[5] = 8'hA1; mem[6] = 8'hB2; mem[7] = 8'hC3;
        run_xfer(5, 3, 0, -1, -1, 0);
    endtask

    task automatic test_wrap();
        run_xfer(6'h3E, 4, 0, -1, -1, 0);
    endtask

    task automatic test_backpressure();
        run_xfer(9, 6, 0, 2, -1, 0);
        run_xfer(30, 12, 50, -1, -1, 0);
    endtask

    task automatic test_full_length();
        run_xfer(0, 0, 0, -1, -1, 1);
    endtask

    task automatic test_reset_mid();
        run_xfer(17, 20, 0, -1, 10, 0);
        run_xfer(6'h20, 2, 0, -1, -1, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            run_xfer(int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom_range(40)), -1, -1, 0);
        end
    endtask

`ifdef READER_CSUM_EN
    task automatic test_csum();
        mem[10] = 8'h01; mem[11] = 8'h02; mem[12] = 8'h03;
        run_xfer(10, 3, 0, -1, -1, 0);
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_full_length();
        test_reset_mid();
        test_back_to_back();
`ifdef READER_CSUM_EN
        test_csum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
